// File: rtl/common_pkg.sv
// Shared types for the memory stage: access sizes, pipeline bundles and data-bus records.
// Widths are fixed for a 64-bit datapath over an 8-byte bus.
package common;

    localparam int XLEN      = 64;
    localparam int BUS_BYTES = 8;
    localparam int OFFSET_W  = 3;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    localparam logic [BUS_BYTES-1:0] MASK_B = 8'h01;
    localparam logic [BUS_BYTES-1:0] MASK_H = 8'h03;
    localparam logic [BUS_BYTES-1:0] MASK_W = 8'h0F;
    localparam logic [BUS_BYTES-1:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        msize_t          msize;
        logic            zeroext;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
    } execute_data_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic            regwrite;
        logic [XLEN-1:0] result;
        logic            misalign;
    } memory_data_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      addr;
        msize_t               size;
        logic [BUS_BYTES-1:0] strobe;
        logic [XLEN-1:0]      data;
    } dbus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    function automatic logic [BUS_BYTES-1:0] size_mask(input msize_t s);
        logic [BUS_BYTES-1:0] m;
        case (s)
            MSIZE_B: m = MASK_B;
            MSIZE_H: m = MASK_H;
            MSIZE_W: m = MASK_W;
            default: m = MASK_D;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the memory stage: misalignment detection, store lane
// placement and load extraction with sign or zero extension. Purely combinational.
module mem_align
    import common::*;
(
    input  logic [OFFSET_W-1:0]  offset,
    input  msize_t               msize,
    input  logic                 zeroext,
    input  logic [XLEN-1:0]      store_data,
    input  logic [XLEN-1:0]      load_data,
    output logic                 misalign,
    output logic [BUS_BYTES-1:0] strobe,
    output logic [XLEN-1:0]      wdata,
    output logic [XLEN-1:0]      load_result
);

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ext [4];

    always_comb begin
        misalign = 1'b0;
        case (msize)
            MSIZE_B: misalign = 1'b0;
            MSIZE_H: misalign = offset[0];
            MSIZE_W: misalign = |offset[1:0];
            default: misalign = |offset;
        endcase
    end

    assign strobe = size_mask(msize) << offset;
    assign wdata  = store_data << {offset, 3'b000};
    assign raw    = load_data >> {offset, 3'b000};

    // One extension candidate per access width; the size selects among them.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            localparam int W = 8 << gi;
            if (W == XLEN) begin : g_full
                assign ext[gi] = raw;
            end else begin : g_part
                assign ext[gi] = zeroext ? {{(XLEN-W){1'b0}}, raw[W-1:0]}
                                         : {{(XLEN-W){raw[W-1]}}, raw[W-1:0]};
            end
        end
    endgenerate

    assign load_result = ext[msize];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the data bus, stalls upstream while an
// access is outstanding, and forms the MEM/WB bundle.
module mem_stage
    import common::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          stallM
);

    mem_state_t           state_reg;
    mem_state_t           state_next;
    logic [XLEN-1:0]      capture_reg;
    logic [XLEN-1:0]      capture_next;

    logic                 mem_op;
    logic                 misalign;
    logic                 issue;
    logic                 req_valid;
    logic [BUS_BYTES-1:0] strobe;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      load_result;
    logic                 unused_bits;

    assign unused_bits = dresp.addr_ok;

    mem_align u_align (
        .offset      (dataE.alu_result[OFFSET_W-1:0]),
        .msize       (dataE.msize),
        .zeroext     (dataE.zeroext),
        .store_data  (dataE.store_data),
        .load_data   (capture_reg),
        .misalign    (misalign),
        .strobe      (strobe),
        .wdata       (wdata),
        .load_result (load_result)
    );

    assign mem_op = dataE.valid & (dataE.memread | dataE.memwrite);
    assign issue  = mem_op & ~misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            capture_reg <= '0;
        end else begin
            state_reg   <= state_next;
            capture_reg <= capture_next;
        end
    end

    // DONE always returns to IDLE so the frozen instruction is never re-issued.
    always_comb begin
        state_next   = state_reg;
        capture_next = capture_reg;
        req_valid    = 1'b0;
        stallM       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    req_valid = 1'b1;
                    stallM    = 1'b1;
                    if (dresp.data_ok) begin
                        state_next   = DONE;
                        capture_next = dresp.data;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                req_valid = 1'b1;
                stallM    = 1'b1;
                if (dresp.data_ok) begin
                    state_next   = DONE;
                    capture_next = dresp.data;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        dreq.valid  = req_valid;
        dreq.addr   = dataE.alu_result;
        dreq.size   = dataE.msize;
        dreq.strobe = strobe;
        dreq.data   = wdata;
    end

    always_comb begin
        dataM.valid    = dataE.valid & ~stallM;
        dataM.pc       = dataE.pc;
        dataM.instr    = dataE.instr;
        dataM.rd       = dataE.rd;
        dataM.misalign = mem_op & misalign;
        dataM.regwrite = dataE.regwrite;
        dataM.result   = dataE.alu_result;
        if (mem_op) begin
            if (misalign || dataE.memwrite) begin
                dataM.regwrite = 1'b0;
                dataM.result   = '0;
            end else begin
                dataM.result = load_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, wait states, misalignment, reset
// during an access and back-to-back issue.
module tb_mem_stage;
    import common::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          stallM;

    int n_cmp = 0;
    int n_err = 0;
    int rise_count = 0;
    logic prev_valid = 1'b0;

    mem_stage dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .dreq   (dreq),
        .dresp  (dresp),
        .dataM  (dataM),
        .stallM (stallM)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dreq.valid && !prev_valid) rise_count <= rise_count + 1;
        prev_valid <= dreq.valid;
    end

    function automatic execute_data_t mk_op(input logic rd_en, input logic wr_en,
                                            input msize_t sz, input logic zx,
                                            input logic [63:0] addr, input logic [63:0] sdata);
        execute_data_t d;
        d            = '0;
        d.valid      = 1'b1;
        d.pc         = 64'h0000_0000_8000_1000;
        d.instr      = 32'h0000_3283;
        d.rd         = 5'd5;
        d.regwrite   = rd_en;
        d.memread    = rd_en;
        d.memwrite   = wr_en;
        d.msize      = sz;
        d.zeroext    = zx;
        d.alu_result = addr;
        d.store_data = sdata;
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        dataE = '0;
        dresp = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (dreq.valid !== 1'b0) begin n_err++; $display("FAIL reset_dreq_valid: got %b expected 0", dreq.valid); end
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stallM); end
        n_cmp++; if (dataM.valid !== 1'b0) begin n_err++; $display("FAIL reset_dataM_valid: got %b expected 0", dataM.valid); end
        n_cmp++; if (dataM.result !== 64'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", dataM.result); end
        $display("reset: dreq.valid=%b stallM=%b dataM.valid=%b", dreq.valid, stallM, dataM.valid);
    endtask

    task automatic test_ld();
        @(negedge clk);
        dataE = mk_op(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0008, 64'h0);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hFEDC_BA98_7654_3210};
        #1;
        n_cmp++; if (stallM !== 1'b1) begin n_err++; $display("FAIL ld_stall_issue: got %b expected 1", stallM); end
        n_cmp++; if (dreq.valid !== 1'b1) begin n_err++; $display("FAIL ld_dreq_valid: got %b expected 1", dreq.valid); end
        n_cmp++; if (dreq.addr !== 64'h8000_0008) begin n_err++; $display("FAIL ld_addr: got %h expected 80000008", dreq.addr); end
        n_cmp++; if (dataM.valid !== 1'b0) begin n_err++; $display("FAIL ld_valid_stalled: got %b expected 0", dataM.valid); end
        @(negedge clk);
        dresp = '0;
        #1;
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL ld_stall_done: got %b expected 0", stallM); end
        n_cmp++; if (dreq.valid !== 1'b0) begin n_err++; $display("FAIL ld_done_dreq: got %b expected 0", dreq.valid); end
        n_cmp++; if (dataM.valid !== 1'b1) begin n_err++; $display("FAIL ld_done_valid: got %b expected 1", dataM.valid); end
        n_cmp++; if (dataM.result !== 64'hFEDC_BA98_7654_3210) begin n_err++; $display("FAIL ld_result: got %h expected fedcba9876543210", dataM.result); end
        n_cmp++; if (dataM.regwrite !== 1'b1) begin n_err++; $display("FAIL ld_regwrite: got %b expected 1", dataM.regwrite); end
        n_cmp++; if (dataM.pc !== 64'h8000_1000 || dataM.rd !== 5'd5 || dataM.instr !== 32'h0000_3283) begin
            n_err++; $display("FAIL ld_passthru: got pc=%h rd=%0d instr=%h expected 80001000/5/00003283", dataM.pc, dataM.rd, dataM.instr);
        end
        $display("ld 0x80000008: result=%h regwrite=%b", dataM.result, dataM.regwrite);
        @(negedge clk);
        dataE = '0;
    endtask

    task automatic test_lb_lbu();
        logic [63:0] exp_res [2];
        exp_res[0] = 64'hFFFF_FFFF_FFFF_FF80;
        exp_res[1] = 64'h0000_0000_0000_0080;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dataE = mk_op(1'b1, 1'b0, MSIZE_B, (i == 1), 64'h8000_0003, 64'h0);
            dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0000_0000_80FF_0000};
            #1;
            n_cmp++; if (dreq.strobe !== 8'h08) begin n_err++; $display("FAIL lb_strobe[%0d]: got %h expected 08", i, dreq.strobe); end
            @(negedge clk);
            dresp = '0;
            #1;
            n_cmp++; if (dataM.result !== exp_res[i]) begin n_err++; $display("FAIL lb_result[%0d]: got %h expected %h", i, dataM.result, exp_res[i]); end
            n_cmp++; if (dataM.valid !== 1'b1) begin n_err++; $display("FAIL lb_valid[%0d]: got %b expected 1", i, dataM.valid); end
            $display("%s 0x80000003: result=%h", (i == 1) ? "lbu" : "lb", dataM.result);
            @(negedge clk);
            dataE = '0;
        end
    endtask

    task automatic test_sh_wait();
        dbus_req_t first;
        int stall_cycles;
        @(negedge clk);
        dataE = mk_op(1'b0, 1'b1, MSIZE_H, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
        dresp = '0;
        #1;
        first = dreq;
        stall_cycles = (stallM === 1'b1) ? 1 : 0;
        n_cmp++; if (dreq.valid !== 1'b1) begin n_err++; $display("FAIL sh_dreq_valid: got %b expected 1", dreq.valid); end
        n_cmp++; if (dreq.strobe !== 8'hC0) begin n_err++; $display("FAIL sh_strobe: got %h expected c0", dreq.strobe); end
        n_cmp++; if (dreq.data !== 64'hBEEF_0000_0000_0000) begin n_err++; $display("FAIL sh_data: got %h expected beef000000000000", dreq.data); end
        n_cmp++; if (dreq.addr !== 64'h8000_0006) begin n_err++; $display("FAIL sh_addr: got %h expected 80000006", dreq.addr); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            dresp.addr_ok = (c == 1);
            dresp.data_ok = (c == 3);
            #1;
            if (stallM === 1'b1) stall_cycles++;
            n_cmp++; if (dreq !== first) begin n_err++; $display("FAIL sh_stable[%0d]: got %h expected %h", c, dreq, first); end
        end
        @(negedge clk);
        dresp = '0;
        #1;
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL sh_stall_done: got %b expected 0", stallM); end
        n_cmp++; if (stall_cycles !== 4) begin n_err++; $display("FAIL sh_stall_cycles: got %0d expected 4", stall_cycles); end
        n_cmp++; if (dataM.valid !== 1'b1 || dataM.regwrite !== 1'b0 || dataM.result !== 64'h0) begin
            n_err++; $display("FAIL sh_done_bundle: got valid=%b regwrite=%b result=%h expected 1/0/0", dataM.valid, dataM.regwrite, dataM.result);
        end
        $display("sh 0x80000006: strobe=%h stall_cycles=%0d", first.strobe, stall_cycles);
        @(negedge clk);
        dataE = '0;
    endtask

    task automatic test_misalign();
        @(negedge clk);
        dataE = mk_op(1'b1, 1'b0, MSIZE_W, 1'b0, 64'h8000_0002, 64'h0);
        dresp = '0;
        #1;
        n_cmp++; if (dreq.valid !== 1'b0) begin n_err++; $display("FAIL mis_dreq_valid: got %b expected 0", dreq.valid); end
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b expected 0", stallM); end
        n_cmp++; if (dataM.misalign !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b expected 1", dataM.misalign); end
        n_cmp++; if (dataM.regwrite !== 1'b0) begin n_err++; $display("FAIL mis_regwrite: got %b expected 0", dataM.regwrite); end
        n_cmp++; if (dataM.valid !== 1'b1) begin n_err++; $display("FAIL mis_valid: got %b expected 1", dataM.valid); end
        @(negedge clk);
        dresp.data_ok = 1'b1;
        #1;
        n_cmp++; if (dreq.valid !== 1'b0 || stallM !== 1'b0) begin n_err++; $display("FAIL mis_still_idle: got dreq.valid=%b stallM=%b expected 0/0", dreq.valid, stallM); end
        $display("lw 0x80000002: misalign=%b regwrite=%b", dataM.misalign, dataM.regwrite);
        @(negedge clk);
        dataE = '0;
        dresp = '0;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        dataE = mk_op(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0010, 64'h0);
        dresp = '0;
        @(negedge clk);
        #1;
        n_cmp++; if (dreq.valid !== 1'b1 || stallM !== 1'b1) begin n_err++; $display("FAIL rb_busy: got dreq.valid=%b stallM=%b expected 1/1", dreq.valid, stallM); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dataE = '0;
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1111_2222_3333_4444};
        #1;
        n_cmp++; if (dreq.valid !== 1'b0) begin n_err++; $display("FAIL rb_dreq_valid: got %b expected 0", dreq.valid); end
        n_cmp++; if (dataM.valid !== 1'b0) begin n_err++; $display("FAIL rb_dataM_valid: got %b expected 0", dataM.valid); end
        n_cmp++; if (stallM !== 1'b0) begin n_err++; $display("FAIL rb_stall: got %b expected 0", stallM); end
        @(negedge clk);
        dresp = '0;
        #1;
        n_cmp++; if (dreq.valid !== 1'b0 || stallM !== 1'b0 || dataM.valid !== 1'b0) begin
            n_err++; $display("FAIL rb_late_resp: got dreq.valid=%b stallM=%b dataM.valid=%b expected 0/0/0", dreq.valid, stallM, dataM.valid);
        end
        $display("reset in BUSY: dreq.valid=%b stallM=%b", dreq.valid, stallM);
    endtask

    task automatic test_back_to_back();
        int rises0;
        @(negedge clk);
        rises0 = rise_count;
        dataE = mk_op(1'b0, 1'b0, MSIZE_D, 1'b0, 64'h0000_0000_0000_1234, 64'h0);
        dataE.regwrite = 1'b1;
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1122_3344_5566_7788};
        #1;
        n_cmp++; if (stallM !== 1'b0 || dreq.valid !== 1'b0) begin n_err++; $display("FAIL b2b_add_nostall: got stallM=%b dreq.valid=%b expected 0/0", stallM, dreq.valid); end
        n_cmp++; if (dataM.valid !== 1'b1 || dataM.result !== 64'h1234 || dataM.regwrite !== 1'b1) begin
            n_err++; $display("FAIL b2b_add_bundle: got valid=%b result=%h regwrite=%b expected 1/1234/1", dataM.valid, dataM.result, dataM.regwrite);
        end
        @(negedge clk);
        dataE = mk_op(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0020, 64'h0);
        #1;
        n_cmp++; if (stallM !== 1'b1) begin n_err++; $display("FAIL b2b_ld_stall: got %b expected 1", stallM); end
        @(negedge clk);
        #1;
        n_cmp++; if (stallM !== 1'b0 || dataM.result !== 64'h1122_3344_5566_7788) begin
            n_err++; $display("FAIL b2b_ld_done: got stallM=%b result=%h expected 0/1122334455667788", stallM, dataM.result);
        end
        @(negedge clk);
        dataE = mk_op(1'b0, 1'b1, MSIZE_D, 1'b0, 64'h8000_0028, 64'h0000_0000_0000_CAFE);
        #1;
        n_cmp++; if (dreq.valid !== 1'b1 || dreq.strobe !== 8'hFF || dreq.data !== 64'hCAFE) begin
            n_err++; $display("FAIL b2b_sd_issue: got valid=%b strobe=%h data=%h expected 1/ff/cafe", dreq.valid, dreq.strobe, dreq.data);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (stallM !== 1'b0 || dataM.valid !== 1'b1) begin n_err++; $display("FAIL b2b_sd_done: got stallM=%b valid=%b expected 0/1", stallM, dataM.valid); end
        @(negedge clk);
        dataE = '0;
        dresp = '0;
        @(negedge clk);
        n_cmp++; if (rise_count - rises0 !== 2) begin n_err++; $display("FAIL b2b_issue_count: got %0d expected 2", rise_count - rises0); end
        $display("back-to-back add/ld/sd: dreq.valid rises=%0d", rise_count - rises0);
    endtask

    initial begin
        test_reset();
        test_ld();
        test_lb_lbu();
        test_sh_wait();
        test_misalign();
        test_reset_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. Consumes the execute-stage bundle held by the EX/MEM register. Performs loads and stores over the data bus with a request/response handshake, and produces the memory-stage bundle for the MEM/WB register. While a bus access is outstanding it asserts a stall that freezes the EX/MEM register and all earlier stages.

## Interface
- Parameters: none. Widths come from package `common`: XLEN=64, 8-byte bus, 3-bit byte offset.
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `dataE`  in  execute_data_t  EX/MEM register output. Fields: valid, pc, instr, rd, regwrite, memread, memwrite, msize (B/H/W/D), zeroext, alu_result (the address), store_data.
- `dreq`  out  dbus_req_t  fields: valid, addr, size, strobe[7:0], data[63:0]
- `dresp`  in  dbus_resp_t  fields: addr_ok, data_ok, data[63:0]
- `dataM`  out  memory_data_t  fields: valid, pc, instr, rd, regwrite, result, misalign
- `stallM`  out  1  freeze request to EX/MEM and upstream registers

## Operation
- A memory op is `dataE.valid & (memread | memwrite)`. Other valid instructions pass through combinationally: result = alu_result, stallM=0, no bus activity.
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE and clears the capture register to 0.
- IDLE, aligned memory op:
  - dreq.valid=1, stallM=1.
  - On data_ok → DONE, capture dresp.data.
  - Otherwise → BUSY.
- BUSY:
  - dreq.valid=1; addr, size, strobe and data held stable.
  - stallM=1.
  - On data_ok → DONE with capture. addr_ok alone is ignored.
- DONE:
  - dreq.valid=0, stallM=0.
  - dataM.valid=1 with the captured load result.
  - Next cycle → IDLE unconditionally, so the same instruction is never re-issued.
- Misaligned op (address not a multiple of the size):
  - No request issued, stallM=0, FSM stays IDLE.
  - dataM.misalign=1, regwrite forced 0.
- Store path:
  - strobe = size mask (B=0x01, H=0x03, W=0x0F, D=0xFF) << addr[2:0].
  - data = store_data << (8*addr[2:0]).
  - dreq.addr = alu_result unchanged.
- Load path:
  - Raw = dresp.data >> (8*addr[2:0]), truncated to msize.
  - Sign-extended to 64 bits, or zero-extended when zeroext=1.
  - Stores produce result=0 and regwrite=0.
- dataM carries pc, instr and rd straight from dataE.
- dataM.valid = dataE.valid, except 0 while stallM=1.

## Timing
- Minimum added latency for a memory op: 1 cycle. Cycle n: request issued and data_ok seen. Cycle n+1: DONE, result valid, stall released.
- Bus latency of k cycles until data_ok gives stallM high for k+1 cycles.
- addr_ok and data_ok may arrive in the same cycle as valid; this is legal and handled.
- data_ok while in IDLE or DONE (stale response) is ignored.
- reset asserted in BUSY: FSM → IDLE on that edge, and dreq.valid=0 from the following cycle. The bus side must drop the transaction.
- Back-to-back memory ops: the second op issues in the cycle after DONE. There is no bubble beyond the DONE cycle.
- Outputs after reset with dataE.valid=0: dreq.valid=0, stallM=0, dataM.valid=0, result=0.

## Structure
- Package `common` holds:
  - msize_t enum
  - execute_data_t, memory_data_t, dbus_req_t, dbus_resp_t
  - the constant size masks
- Sub-module `mem_align` (purely combinational) provides:
  - misalign detection
  - strobe and store-data shifting
  - load extraction and extension
- `mem_stage` holds the FSM, the capture register and the pass-through muxing.

## Test plan
- ld at 0x80000008, memory word 0xFEDCBA9876543210, data_ok same cycle → stallM high 1 cycle; DONE cycle result=0xFEDCBA9876543210, regwrite=1.
- lb at 0x80000003 with bus data 0x00000000_80FF0000 → result=0xFFFFFFFFFFFFFF80. lbu at the same address → result=0x80.
- sh at 0x80000006, store_data=0xBEEF → strobe=0xC0, data=0xBEEF000000000000. dreq stays stable across 3 wait cycles until data_ok; stallM high 4 cycles.
- lw at 0x80000002 → no dreq.valid, stallM=0, misalign=1, regwrite=0.
- Request in BUSY, reset pulsed one cycle, then a late data_ok → FSM IDLE, dreq.valid=0, dataM.valid=0, late response ignored.
- add then ld then sd back-to-back → add passes with zero stall; each memory op issues exactly once, confirmed by counting dreq.valid rising edges (2).
